pipeline_debug_ctrl: RTL and testbench

//  Program-load and run sequencer for the MIPS pipeline. It receives a byte stream (commands and

---
 rtl/pipeline_debug_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_debug_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_debug_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_debug_ctrl
//  Description : Program-load and run sequencer between the host byte link
//                and the MIPS pipeline (IF memory load, reset, run/step).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_debug_ctrl #(
    parameter int                 NB_DATA    = 32,
    parameter int                 NB_COUNT   = 8,
    parameter int                 RST_CYCLES = 2,
    parameter logic [NB_DATA-1:0] HALT_WORD  = {NB_DATA{1'b1}}
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_rx_valid,
    input  logic [7:0]          i_rx_data,
    output logic                o_rx_ready,
    input  logic                i_halt_detected,
    output logic                o_pipe_rst_n,
    output logic                o_we_IF,
    output logic [NB_DATA-1:0]  o_instruction_data,
    output logic                o_halt,
    output logic [NB_COUNT-1:0] o_instr_count,
    output logic [2:0]          o_state
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_WRITE = 3'd2;
    localparam logic [2:0] c_ST_FLUSH = 3'd3;
    localparam logic [2:0] c_ST_ARMED = 3'd4;
    localparam logic [2:0] c_ST_RUN   = 3'd5;
    localparam logic [2:0] c_ST_STEP  = 3'd6;
    localparam logic [2:0] c_ST_DONE  = 3'd7;

    localparam logic [7:0] c_CMD_L = 8'h4C;
    localparam logic [7:0] c_CMD_C = 8'h43;
    localparam logic [7:0] c_CMD_S = 8'h53;
    localparam logic [7:0] c_CMD_R = 8'h52;

    localparam int c_BYTES = NB_DATA / 8;
    localparam int c_BCW   = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam int c_FCW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [c_BCW-1:0]    c_LAST_BYTE  = c_BCW'(c_BYTES - 1);
    localparam logic [c_FCW-1:0]    c_FLUSH_LAST = c_FCW'(RST_CYCLES - 1);
    localparam logic [NB_COUNT-1:0] c_COUNT_MAX  = {NB_COUNT{1'b1}};

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_BCW-1:0]   r_byte_cnt;
    logic [c_FCW-1:0]   r_flush_cnt;
    logic [NB_DATA-9:0] r_word;
    logic [NB_DATA-1:0] w_word_next;
    logic               w_accept;
    logic               w_new_load;

    assign w_accept    = i_rx_valid & o_rx_ready;
    assign w_word_next = {r_word, i_rx_data};
    // Entering LOAD from a command state starts a fresh program.
    assign w_new_load  = (w_next_state == c_ST_LOAD) &&
                         (r_state != c_ST_LOAD) && (r_state != c_ST_WRITE);
    assign o_state     = r_state;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept && i_rx_data == c_CMD_L) w_next_state = c_ST_LOAD;
            end
            c_ST_LOAD: begin
                if (w_accept && r_byte_cnt == c_LAST_BYTE) w_next_state = c_ST_WRITE;
            end
            c_ST_WRITE: begin
                if (o_instruction_data == HALT_WORD || o_instr_count == c_COUNT_MAX)
                    w_next_state = c_ST_FLUSH;
                else
                    w_next_state = c_ST_LOAD;
            end
            c_ST_FLUSH: begin
                if (r_flush_cnt == c_FLUSH_LAST) w_next_state = c_ST_ARMED;
            end
            c_ST_ARMED: begin
                if (w_accept) begin
                    if (i_rx_data == c_CMD_L)      w_next_state = c_ST_LOAD;
                    else if (i_rx_data == c_CMD_C) w_next_state = c_ST_RUN;
                    else if (i_rx_data == c_CMD_S) w_next_state = c_ST_STEP;
                end
            end
            c_ST_RUN: begin
                if (i_halt_detected) w_next_state = c_ST_DONE;
            end
            c_ST_STEP: begin
                w_next_state = i_halt_detected ? c_ST_DONE : c_ST_ARMED;
            end
            c_ST_DONE: begin
                if (w_accept) begin
                    if (i_rx_data == c_CMD_R)      w_next_state = c_ST_FLUSH;
                    else if (i_rx_data == c_CMD_L) w_next_state = c_ST_LOAD;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered with it.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state            <= c_ST_IDLE;
            r_byte_cnt         <= '0;
            r_flush_cnt        <= '0;
            r_word             <= '0;
            o_rx_ready         <= 1'b0;
            o_pipe_rst_n       <= 1'b0;
            o_we_IF            <= 1'b0;
            o_instruction_data <= '0;
            o_halt             <= 1'b1;
            o_instr_count      <= '0;
        end else begin
            r_state      <= w_next_state;
            o_rx_ready   <= (w_next_state == c_ST_IDLE) || (w_next_state == c_ST_LOAD) ||
                            (w_next_state == c_ST_ARMED) || (w_next_state == c_ST_DONE);
            o_pipe_rst_n <= (w_next_state != c_ST_IDLE) && (w_next_state != c_ST_FLUSH);
            o_halt       <= (w_next_state != c_ST_RUN) && (w_next_state != c_ST_STEP);
            o_we_IF      <= (w_next_state == c_ST_WRITE);

            r_flush_cnt <= (r_state == c_ST_FLUSH) ? r_flush_cnt + c_FCW'(1) : '0;

            if (w_accept && r_state == c_ST_LOAD) begin
                r_word     <= w_word_next[NB_DATA-9:0];
                r_byte_cnt <= (r_byte_cnt == c_LAST_BYTE) ? '0 : r_byte_cnt + c_BCW'(1);
            end

            if (r_state == c_ST_LOAD && w_next_state == c_ST_WRITE) begin
                o_instruction_data <= w_word_next;
                if (o_instr_count != c_COUNT_MAX)
                    o_instr_count <= o_instr_count + NB_COUNT'(1);
            end

            if (w_new_load) begin
                o_instr_count <= '0;
                r_byte_cnt    <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_debug_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_debug_ctrl
//  Description : Self-checking bench for pipeline_debug_ctrl (load/run/step).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        halt_det = 1'b0;
    logic        rx_ready, pipe_rst_n, we_if, halt;
    logic [31:0] instr_data;
    logic [7:0]  instr_count;
    logic [2:0]  state;

    logic        rx_valid2 = 1'b0;
    logic [7:0]  rx_data2 = 8'h00;
    logic        rx_ready2, pipe_rst_n2, we_if2, halt2;
    logic [31:0] instr_data2;
    logic [1:0]  instr_count2;
    logic [2:0]  state2;

    int n_checks = 0;
    int n_fail = 0;
    int n_timeout = 0;
    logic [31:0] wr_q[$];

    always #5 clk = ~clk;

    pipeline_debug_ctrl dut (
        .clk(clk), .i_rst(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_rx_ready(rx_ready), .i_halt_detected(halt_det), .o_pipe_rst_n(pipe_rst_n),
        .o_we_IF(we_if), .o_instruction_data(instr_data), .o_halt(halt),
        .o_instr_count(instr_count), .o_state(state)
    );

    pipeline_debug_ctrl #(.NB_COUNT(2)) dut2 (
        .clk(clk), .i_rst(rst), .i_rx_valid(rx_valid2), .i_rx_data(rx_data2),
        .o_rx_ready(rx_ready2), .i_halt_detected(1'b0), .o_pipe_rst_n(pipe_rst_n2),
        .o_we_IF(we_if2), .o_instruction_data(instr_data2), .o_halt(halt2),
        .o_instr_count(instr_count2), .o_state(state2)
    );

    always @(negedge clk) if (we_if) wr_q.push_back(instr_data);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) tick();
        n = 0;
        while (!rx_ready && n < 50) begin tick(); n++; end
        if (!rx_ready) n_timeout++;
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 3; i >= 0; i--)
            send_byte(w[8*i +: 8], $urandom_range(0, max_gap));
    endtask

    task automatic send_byte2(input logic [7:0] b);
        int n;
        n = 0;
        while (!rx_ready2 && n < 50) begin tick(); n++; end
        if (!rx_ready2) n_timeout++;
        rx_valid2 = 1'b1;
        rx_data2  = b;
        tick();
        rx_valid2 = 1'b0;
    endtask

    // Counts cycles with pipe reset low until ARMED is reached (or bound expires).
    task automatic wait_armed(output int low_cycles);
        int n;
        low_cycles = 0;
        n = 0;
        while (state != 3'd4 && n < 40) begin
            if (!pipe_rst_n) low_cycles++;
            tick();
            n++;
        end
        if (state != 3'd4) n_timeout++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if (state !== 3'd0 || rx_ready !== 1'b0 || pipe_rst_n !== 1'b0 || we_if !== 1'b0 ||
            instr_data !== 32'h0 || halt !== 1'b1 || instr_count !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_values: state=%0d rdy=%b rst_n=%b we=%b data=%h halt=%b cnt=%0d, required 0 0 0 0 0 1 0",
                     state, rx_ready, pipe_rst_n, we_if, instr_data, halt, instr_count);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (rx_ready !== 1'b1 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b state=%0d, required 1 0", rx_ready, state);
        end
    endtask

    task automatic test_load();
        int low;
        wr_q.delete();
        send_byte(8'h4C, 0);
        n_checks++;
        if (state !== 3'd1 || pipe_rst_n !== 1'b1 || halt !== 1'b1) begin
            n_fail++;
            $display("FAIL load_enter: state=%0d rst_n=%b halt=%b, required 1 1 1", state, pipe_rst_n, halt);
        end
        send_word(32'h2001000F, 0);
        n_checks++;
        if (state !== 3'd2 || we_if !== 1'b1 || rx_ready !== 1'b0 || instr_data !== 32'h2001000F) begin
            n_fail++;
            $display("FAIL write_cycle: state=%0d we=%b rdy=%b data=%h, required 2 1 0 2001000f",
                     state, we_if, rx_ready, instr_data);
        end
        send_word(32'hFFFFFFFF, 0);
        wait_armed(low);
        n_checks++;
        if (wr_q.size() != 2 || wr_q[0] !== 32'h2001000F || wr_q[1] !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL load_words: got %0d writes first=%h, required 2 writes 2001000f ffffffff",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 32'hx);
        end
        n_checks++;
        if (instr_count !== 8'd2 || low != 2 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL load_flush: cnt=%0d low_cycles=%0d state=%0d, required 2 2 4", instr_count, low, state);
        end
    endtask

    task automatic test_step();
        for (int k = 0; k < 3; k++) begin
            send_byte(8'h53, k);
            n_checks++;
            if (state !== 3'd6 || halt !== 1'b0) begin
                n_fail++;
                $display("FAIL step_pulse[%0d]: state=%0d halt=%b, required 6 0", k, state, halt);
            end
            tick();
            n_checks++;
            if (state !== 3'd4 || halt !== 1'b1) begin
                n_fail++;
                $display("FAIL step_return[%0d]: state=%0d halt=%b, required 4 1", k, state, halt);
            end
        end
        halt_det = 1'b1;
        tick();
        halt_det = 1'b0;
        n_checks++;
        if (state !== 3'd4) begin
            n_fail++;
            $display("FAIL halt_ignored_armed: state=%0d, required 4", state);
        end
    endtask

    task automatic test_run_rerun();
        int low;
        send_byte(8'h43, 0);
        for (int c = 0; c < 9; c++) tick();
        n_checks++;
        if (state !== 3'd5 || halt !== 1'b0 || rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL run_active: state=%0d halt=%b rdy=%b, required 5 0 0", state, halt, rx_ready);
        end
        halt_det = 1'b1;
        tick();
        halt_det = 1'b0;
        n_checks++;
        if (state !== 3'd7 || halt !== 1'b1 || rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL run_done: state=%0d halt=%b rdy=%b, required 7 1 1", state, halt, rx_ready);
        end
        send_byte(8'h52, 0);
        wait_armed(low);
        n_checks++;
        if (low != 2 || state !== 3'd4 || instr_count !== 8'd2) begin
            n_fail++;
            $display("FAIL rerun: low_cycles=%0d state=%0d cnt=%0d, required 2 4 2", low, state, instr_count);
        end
    endtask

    task automatic test_reset_midload();
        wr_q.delete();
        send_byte(8'h4C, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b1;
        tick();
        n_checks++;
        if (state !== 3'd0 || instr_count !== 8'd0 || we_if !== 1'b0 || rx_ready !== 1'b0 || halt !== 1'b1) begin
            n_fail++;
            $display("FAIL midload_reset: state=%0d cnt=%0d we=%b rdy=%b halt=%b, required 0 0 0 0 1",
                     state, instr_count, we_if, rx_ready, halt);
        end
        rst = 1'b0;
        tick();
        send_byte(8'h4C, 0);
        send_word(32'h12345678, 1);
        tick();
        n_checks++;
        if (wr_q.size() != 1 || wr_q[0] !== 32'h12345678 || instr_count !== 8'd1 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL clean_word: writes=%0d word=%h cnt=%0d state=%0d, required 1 12345678 1 1",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 32'hx, instr_count, state);
        end
    endtask

    task automatic test_random_programs();
        logic [31:0] exp_q[$];
        logic [31:0] w;
        logic [7:0]  b;
        logic [2:0]  exp_state;
        int          k, low;
        for (int p = 0; p < 4; p++) begin
            do_reset();
            wr_q.delete();
            exp_q.delete();
            send_byte(8'h4C, $urandom_range(0, 2));
            k = $urandom_range(1, 6);
            for (int i = 0; i < k; i++) begin
                w = $urandom;
                if (w == 32'hFFFFFFFF) w = 32'h0;
                exp_q.push_back(w);
                send_word(w, 2);
            end
            exp_q.push_back(32'hFFFFFFFF);
            send_word(32'hFFFFFFFF, 2);
            wait_armed(low);
            n_checks++;
            if (wr_q.size() != exp_q.size() || instr_count !== 8'(exp_q.size()) || low != 2) begin
                n_fail++;
                $display("FAIL rand_prog[%0d]: writes=%0d cnt=%0d low=%0d, required %0d %0d 2",
                         p, wr_q.size(), instr_count, low, exp_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
                n_checks++;
                if (wr_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_word[%0d][%0d]: got %h, required %h", p, i, wr_q[i], exp_q[i]);
                end
            end
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    b = 8'h53;
                    exp_state = 3'd6;
                end else begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'h4C || b == 8'h43 || b == 8'h53 || b == 8'h52) b = 8'h00;
                    exp_state = 3'd4;
                end
                send_byte(b, 0);
                n_checks++;
                if (state !== exp_state) begin
                    n_fail++;
                    $display("FAIL rand_cmd[%0d][%0d] byte %h: state=%0d, required %0d", p, c, b, state, exp_state);
                end
                if (exp_state == 3'd6) tick();
            end
        end
    endtask

    task automatic test_memory_full();
        do_reset();
        send_byte2(8'h58);
        n_checks++;
        if (state2 !== 3'd0 || rx_ready2 !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_junk: state=%0d rdy=%b, required 0 1", state2, rx_ready2);
        end
        send_byte2(8'h4C);
        for (int i = 0; i < 3; i++) begin
            send_byte2(8'h10); send_byte2(8'h20); send_byte2(8'h30); send_byte2(8'(i));
        end
        tick();
        n_checks++;
        if (state2 !== 3'd3 || instr_count2 !== 2'd3 || pipe_rst_n2 !== 1'b0 || instr_data2 !== 32'h10203002) begin
            n_fail++;
            $display("FAIL mem_full: state=%0d cnt=%0d rst_n=%b data=%h, required 3 3 0 10203002",
                     state2, instr_count2, pipe_rst_n2, instr_data2);
        end
    endtask

    task automatic test_no_timeouts();
        n_checks++;
        if (n_timeout !== 0) begin
            n_fail++;
            $display("FAIL handshake_timeouts: got %0d, required 0", n_timeout);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_step();
        test_run_rerun();
        test_reset_midload();
        test_random_programs();
        test_memory_full();
        test_no_timeouts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
